// File: rtl/bsg_gatestack_pkg.sv
// bsg_gatestack_pkg: shared state encoding and sizing helpers for the gatestack strobe generator
package bsg_gatestack_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} bsg_gatestack_state_e;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/bsg_gatestack_phase_timer.sv
// bsg_gatestack_phase_timer: loadable down-counter that parks at zero and flags it
module bsg_gatestack_phase_timer
    import bsg_gatestack_pkg::*;
#(
    parameter int max_count_p = 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  load_i,
    input  logic [safe_clog2(max_count_p)-1:0]    load_val_i,
    output logic                                  zero_o
);

    logic [safe_clog2(max_count_p)-1:0] count_q, count_d;

    always_comb begin
        count_d = load_i ? load_val_i : ((count_q != '0) ? count_q - 1'b1 : count_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) count_q <= '0;
        else         count_q <= count_d;
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/bsg_gatestack_strobe_gen.sv
// bsg_gatestack_strobe_gen: replays an accepted word as setup/pulse/hold data+strobe to a gated flop bank
module bsg_gatestack_strobe_gen
    import bsg_gatestack_pkg::*;
#(
    parameter int width_p        = 16,
    parameter int setup_cycles_p = 1,
    parameter int pulse_cycles_p = 1,
    parameter int hold_cycles_p  = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic [width_p-1:0] mask_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic [width_p-1:0] strobe_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int max_lp = max3(setup_cycles_p, pulse_cycles_p, hold_cycles_p);
    localparam int tw_lp  = safe_clog2(max_lp);

    bsg_gatestack_state_e state_q, state_d;
    logic [width_p-1:0]   data_q, data_d, mask_q, mask_d, strobe_q, strobe_d;
    logic                 done_q, done_d, ready_q, ready_d;
    logic                 load, tzero;
    logic [tw_lp-1:0]     load_val;

    wire xfer = v_i & ready_q;

    bsg_gatestack_phase_timer #(.max_count_p(max_lp)) timer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (load),
        .load_val_i(load_val),
        .zero_o    (tzero)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        mask_d   = mask_q;
        strobe_d = strobe_q;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            IDLE: if (xfer) begin
                state_d  = SETUP;
                data_d   = data_i;
                mask_d   = mask_i;
                load     = 1'b1;
                load_val = tw_lp'(setup_cycles_p - 1);
            end
            SETUP: if (tzero) begin
                state_d  = PULSE;
                strobe_d = mask_q;
                load     = 1'b1;
                load_val = tw_lp'(pulse_cycles_p - 1);
            end
            PULSE: if (tzero) begin
                state_d  = HOLD;
                strobe_d = '0;
                load     = 1'b1;
                load_val = tw_lp'(hold_cycles_p - 1);
            end
            HOLD: if (tzero) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d  = (state_q == HOLD) && tzero;
        ready_d = (state_d == IDLE);
    end

    // ready is registered from the next state so every output leaves a flop directly
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            data_q   <= '0;
            mask_q   <= '0;
            strobe_q <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign ready_o  = ready_q;
    assign busy_o   = ~ready_q;
    assign data_o   = data_q;
    assign strobe_o = strobe_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_bsg_gatestack_strobe_gen.sv
// tb_bsg_gatestack_strobe_gen: directed vectors with a done-driven scoreboard and a gated-bank model
module tb_bsg_gatestack_strobe_gen;

    logic clk = 1'b0, reset = 1'b1, v = 1'b0, sel = 1'b0;
    logic [15:0] d_in = '0, m_in = '0;
    logic ready_a, busy_a, done_a, ready_b, busy_b, done_b;
    logic [15:0] data_a, strobe_a, data_b, strobe_b;

    always #5 clk = ~clk;

    bsg_gatestack_strobe_gen dut_a (
        .clk_i(clk), .reset_i(reset), .v_i(v & ~sel), .data_i(d_in), .mask_i(m_in),
        .ready_o(ready_a), .data_o(data_a), .strobe_o(strobe_a), .busy_o(busy_a), .done_o(done_a)
    );

    bsg_gatestack_strobe_gen #(.setup_cycles_p(2), .pulse_cycles_p(3), .hold_cycles_p(2)) dut_b (
        .clk_i(clk), .reset_i(reset), .v_i(v & sel), .data_i(d_in), .mask_i(m_in),
        .ready_o(ready_b), .data_o(data_b), .strobe_o(strobe_b), .busy_o(busy_b), .done_o(done_b)
    );

    wire        ready_m  = sel ? ready_b  : ready_a;
    wire        busy_m   = sel ? busy_b   : busy_a;
    wire        done_m   = sel ? done_b   : done_a;
    wire [15:0] data_m   = sel ? data_b   : data_a;
    wire [15:0] strobe_m = sel ? strobe_b : strobe_a;

    typedef struct packed { logic [15:0] data; logic [15:0] bank; } exp_t;
    exp_t sb[$];
    int n_vec = 0, n_bad = 0;
    logic [15:0] bank = '0, exp_bank = '0, prev_s = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // downstream gated bank: each lane captures data_o on its own strobe rising edge
    always @(negedge clk) begin
        logic [15:0] r;
        r = strobe_m & ~prev_s;
        bank = (bank & ~r) | (data_m & r);
        prev_s = strobe_m;
    end

    always @(negedge clk) begin
        if (done_m) begin
            if (sb.size() == 0) check("spurious_done", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_data", data_m, e.data);
                check("sb_bank", bank, e.bank);
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic [15:0] m, input int s, input int p, input int h);
        int t;
        t = s + p + h;
        check("ready_before", ready_m, 1);
        v = 1'b1; d_in = d; m_in = m;
        exp_bank = (exp_bank & ~m) | (d & m);
        sb.push_back({d, exp_bank});
        @(posedge clk);
        #1 v = 1'b0; d_in = 16'(~d); m_in = 16'hFFFF;
        for (int k = 0; k <= t; k++) begin
            @(negedge clk);
            check("strobe", strobe_m, (k >= s && k < s + p) ? m : 16'h0);
            check("data",   data_m, d);
            check("ready",  ready_m, k == t);
            check("busy",   busy_m, k != t);
            check("done",   done_m, k == t);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("rst_ready_a", ready_a, 1);   check("rst_ready_b", ready_b, 1);
            check("rst_strobe_a", strobe_a, 0); check("rst_strobe_b", strobe_b, 0);
            check("rst_data_a", data_a, 0);     check("rst_data_b", data_b, 0);
            check("rst_done_a", done_a, 0);     check("rst_done_b", done_b, 0);
        end
        send(16'hA5C3, 16'hFFFF, 1, 1, 1);
        @(negedge clk);
        send(16'hBEEF, 16'h0000, 1, 1, 1);
        @(negedge clk);
        sel = 1'b1;
        @(negedge clk);
        send(16'h7E18, 16'h0081, 2, 3, 2);
        repeat (3) begin
            @(negedge clk);
            check("data_held", data_m, 16'h7E18);
        end
        send(16'hC0DE, 16'hF0F0, 2, 3, 2);
        send(16'h1234, 16'h000F, 2, 3, 2);
        @(negedge clk);
        sel = 1'b0;
        @(negedge clk);
        v = 1'b1; d_in = 16'h5A5A; m_in = 16'h00FF;
        exp_bank = (exp_bank & ~16'h00FF) | (16'h5A5A & 16'h00FF);
        sb.push_back({16'h5A5A, exp_bank});
        @(posedge clk);
        #1 v = 1'b0;
        @(negedge clk);
        check("abort_setup_strobe", strobe_m, 16'h0);
        @(negedge clk);
        check("abort_pulse_strobe", strobe_m, 16'h00FF);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_strobe", strobe_m, 16'h0);
        check("abort_data",   data_m, 16'h0);
        check("abort_ready",  ready_m, 1);
        check("abort_done",   done_m, 0);
        repeat (5) begin
            @(negedge clk);
            check("abort_no_done", done_m, 0);
        end
        send(16'h0F0F, 16'hFFFF, 1, 1, 1);
        @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("bank_final", bank, exp_bank);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
